// File: rtl/lc330_boot_loader.sv
// Boot loader for the lc330 core: holds the core in reset, streams a length-prefixed
// little-endian program image into instruction memory, then releases the core after a hold time.
module lc330_boot_loader #(
  parameter int ADDR_W      = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;
  localparam int HW        = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {S_COUNT, S_LOAD, S_HOLD, S_RUN, S_ERROR} state_t;

  state_t            state, state_next;
  logic [1:0]        byte_idx;
  logic [7:0]        n_lo;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   words_rcvd, rcvd_next;
  logic [23:0]       asm_word;
  logic [31:0]       word_buf;
  logic              word_pend;
  logic [HW-1:0]     hold_cnt;
  logic              ready_next;
  logic              accept;
  logic              last_write;
  logic [15:0]       count_full;

  assign accept     = in_valid & in_ready;
  assign count_full = {in_data, n_lo};
  assign last_write = ((words_loaded + 1'b1) == n_words);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_COUNT;
    else      state <= state_next;
  end

  // in_ready is registered, so it drops on the same edge that accepts the final image byte.
  always_comb begin
    state_next = state;
    rcvd_next  = words_rcvd;
    case (state)
      S_COUNT: begin
        if (accept && byte_idx[0]) begin
          if (count_full == 16'd0)                      state_next = S_HOLD;
          else if (32'(count_full) > 32'(MEM_DEPTH))    state_next = S_ERROR;
          else                                          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept && byte_idx == 2'd3) rcvd_next = words_rcvd + 1'b1;
        if (mem_we && last_write)       state_next = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt == '0) state_next = S_RUN;
      end
      default: ;
    endcase
    ready_next = (state_next == S_COUNT) ||
                 ((state_next == S_LOAD) && ((state != S_LOAD) || (rcvd_next != n_words)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      byte_idx     <= '0;
      n_lo         <= '0;
      n_words      <= '0;
      words_rcvd   <= '0;
      asm_word     <= '0;
      word_buf     <= '0;
      word_pend    <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      in_ready   <= ready_next;
      cpu_rst    <= (state_next != S_RUN);
      done       <= (state_next == S_RUN);
      error      <= (state_next == S_ERROR);
      mem_we     <= word_pend;
      word_pend  <= 1'b0;
      words_rcvd <= rcvd_next;
      if (word_pend) mem_wdata <= word_buf;

      if (accept && state == S_COUNT) begin
        if (!byte_idx[0]) n_lo <= in_data;
        else              n_words <= count_full[ADDR_W:0];
        byte_idx <= byte_idx[0] ? 2'd0 : 2'd1;
      end else if (accept && state == S_LOAD) begin
        if (byte_idx == 2'd3) begin
          word_buf  <= {in_data, asm_word};
          word_pend <= 1'b1;
        end else begin
          asm_word <= {in_data, asm_word[23:8]};
        end
        byte_idx <= byte_idx + 2'd1;
      end

      // The final word keeps its address so a full-depth image never wraps back to 0.
      if (mem_we) begin
        words_loaded <= words_loaded + 1'b1;
        if (!last_write) mem_addr <= mem_addr + 1'b1;
      end

      if (state_next == S_HOLD && state != S_HOLD)
        hold_cnt <= HW'(HOLD_CYCLES);
      else if (state == S_HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_lc330_boot_loader.sv
// Randomized bench for lc330_boot_loader: images are streamed with varied valid patterns
// and memory writes, final status and release timing are compared to an image-level model.
module tb_lc330_boot_loader;

  localparam int ADDR_W = 2;
  localparam int HOLD   = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  int          last_acc_cyc = 0;
  int          valid_mode = 0;
  int          img_n = 0;
  logic [31:0] img_w[$];
  logic [7:0]  stim[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];

  lc330_boot_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    if (obs !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, expected, cyc);
    end
  endtask

  // Every write strobe must match the next entry of the expected write list, in order.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      last_we_cyc = cyc;
      if (exp_addr.size() == 0) checkOutput("unexpected_we", 32'd1, 32'd0);
      else begin
        checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
        checkOutput("mem_wdata", mem_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic randomImage(input int n);
    img_n = n;
    img_w.delete();
    if (n <= DEPTH)
      for (int i = 0; i < n; i++) img_w.push_back($urandom);
  endtask

  task automatic prepImage();
    logic [15:0] cnt;
    logic [31:0] w;
    stim.delete();
    exp_addr.delete();
    exp_data.delete();
    cnt = 16'(img_n);
    stim.push_back(cnt[7:0]);
    stim.push_back(cnt[15:8]);
    if (img_n >= 1 && img_n <= DEPTH) begin
      for (int i = 0; i < img_n; i++) begin
        w = img_w[i];
        for (int b = 0; b < 4; b++) stim.push_back(w[8*b +: 8]);
        exp_addr.push_back(i);
        exp_data.push_back(w);
      end
    end
  endtask

  task automatic applyStimulus(input int nbytes);
    int idx = 0;
    int budget = 0;
    bit acc = 1'b0;
    bit v;
    bit phase = 1'b1;
    while (1) begin
      @(negedge clk);
      if (acc) begin
        idx++;
        last_acc_cyc = cyc;
      end
      acc = 1'b0;
      if (idx >= nbytes) break;
      if (budget >= 2000) begin
        checkOutput("stream_timeout", 32'(idx), 32'(nbytes));
        break;
      end
      budget++;
      case (valid_mode)
        0:       v = 1'b1;
        1:       begin v = phase; phase = ~phase; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? stim[idx] : 8'($urandom);
      acc      = v && (in_ready === 1'b1);
    end
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("ready_after_edge", 32'(in_ready), 32'd1);
    checkOutput("cpu_rst_loading", 32'(cpu_rst), 32'd1);
  endtask

  task automatic finishImage();
    int  waited = 0;
    int  fall_cyc;
    bit  exp_err;
    int  exp_words;
    bit  ready_seen = 1'b0;
    exp_err   = (img_n > DEPTH);
    exp_words = exp_err ? 0 : img_n;
    while (!(done === 1'b1 || error === 1'b1) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    fall_cyc = cyc;
    checkOutput("end_timeout", 32'(waited < 300), 32'd1);
    checkOutput("error", 32'(error), 32'(exp_err));
    checkOutput("done", 32'(done), 32'(!exp_err));
    checkOutput("cpu_rst", 32'(cpu_rst), 32'(exp_err));
    checkOutput("words_loaded", 32'(words_loaded), 32'(exp_words));
    checkOutput("writes_missing", 32'(exp_addr.size()), 32'd0);
    if (!exp_err) begin
      if (img_n == 0) checkOutput("hold_from_count", 32'(fall_cyc - last_acc_cyc), 32'(HOLD + 1));
      else            checkOutput("hold_from_we", 32'(fall_cyc - last_we_cyc), 32'(HOLD + 2));
    end
    in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      in_data = 8'($urandom);
      if (in_ready !== 1'b0) ready_seen = 1'b1;
    end
    in_valid = 1'b0;
    checkOutput("ready_after_end", 32'(ready_seen), 32'd0);
    checkOutput("cpu_rst_stable", 32'(cpu_rst), 32'(exp_err));
    checkOutput("done_stable", 32'(done), 32'(!exp_err));
  endtask

  task automatic runImage(input int mode);
    valid_mode = mode;
    doReset();
    prepImage();
    applyStimulus(stim.size());
    finishImage();
  endtask

  initial begin
    img_n = 2;
    img_w.delete();
    img_w.push_back(32'h12345678);
    img_w.push_back(32'hDEADBEEF);
    runImage(0);
    runImage(1);

    randomImage(0);      runImage(0);
    randomImage(5);      runImage(0);
    randomImage(65535);  runImage(2);
    randomImage(DEPTH);  runImage(2);

    // Reset after six bytes: the half-received image must vanish, then reload cleanly.
    randomImage(2);
    valid_mode = 0;
    doReset();
    prepImage();
    applyStimulus(6);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("mid_rst_words", 32'(words_loaded), 32'd0);
    exp_addr.delete();
    exp_data.delete();
    runImage(1);

    for (int t = 0; t < 12; t++) begin
      randomImage($urandom_range(0, DEPTH + 1));
      runImage($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
